mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port on-chip RAM between NUM_MASTERS processor data masters in the MPSoC.
- The RAM is 32-bit wide with a 15-bit word address and byte enables. It registers the address and has an unregistered output, so read data is valid exactly one cycle after the access cycle.
- The block does round-robin arbitration with optional lock and a bounded lock length.
- It issues at most one RAM access per cycle and routes read data back with a readdatavalid strobe.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 15, word-address width.
- MAX_LOCK, 16, maximum consecutive locked grants before forced re-arbitration (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address; master i occupies slice i.
- m_byteenable  in  NUM_MASTERS*4  per-master byte enables.
- m_read  in  NUM_MASTERS  per-master read request.
- m_write  in  NUM_MASTERS  per-master write request.
- m_writedata  in  NUM_MASTERS*32  per-master write data.
- m_lock  in  NUM_MASTERS  per-master request to keep the grant next cycle.
- m_waitrequest  out  NUM_MASTERS  high = request not accepted this cycle.
- m_readdata  out  32  read data, shared by all masters.
- m_readdatavalid  out  NUM_MASTERS  one-hot strobe marking which master owns m_readdata.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  4  RAM byte enables.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable; tied to 1.
- mem_readdata  in  32  RAM read data.

Behaviour:
- Request definition: master i requests when m_read[i] | m_write[i]. Read and write asserted together is illegal; write takes precedence.
- Arbitration is combinational each cycle.
  - If a lock is active and its owner still requests, the owner wins.
  - Otherwise the winner is the first requester searching from (last_grant+1) mod NUM_MASTERS upward.
- Granted master: m_waitrequest[g]=0 and its request drives the mem_* outputs in the same cycle.
  - mem_chipselect=1; mem_write=m_write[g].
- Non-granted requesters: m_waitrequest=1 and they must hold their request.
- Idle masters: m_waitrequest=1 whenever the master is not granted.
- No requesters: mem_chipselect=0, mem_write=0. The address/data outputs carry don't-care values, driven from master 0's slice.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=g at the clock edge.
  - In the next cycle, m_readdatavalid[rd_owner]=1 and m_readdata=mem_readdata (pass-through, no extra register).
  - Total read latency is 1 cycle after acceptance.
  - Back-to-back reads from any masters are accepted every cycle: the response pipeline is one deep and fully pipelined.
- Writes produce no response.
- last_grant register updates to g on every granted cycle and holds on idle cycles.
- Lock state:
  - lock_act is set when the granted master has m_lock[g]=1; lock_owner=g and lock_cnt increments.
  - lock_act clears when the owner deasserts m_lock, when the owner stops requesting, or when lock_cnt reaches MAX_LOCK.
  - On a MAX_LOCK expiry, that cycle's grant is still honoured. The next cycle arbitrates round-robin from lock_owner+1, ignoring m_lock for that single cycle.
  - lock_cnt resets to 0 whenever lock_act clears.
  - Lock of a non-requesting owner is released immediately and does not stall others.
- Reset (asynchronous, reset_n=0):
  - last_grant=NUM_MASTERS-1, so master 0 has first priority.
  - rd_pend=0, lock_act=0, lock_cnt=0.
  - Outputs during reset: m_waitrequest all 1, m_readdatavalid all 0, mem_chipselect=0, mem_write=0, mem_clken=1.
  - Reset asserted mid-read drops the pending response: no readdatavalid after release.
- Release: first grant is possible on the first clk edge after reset_n deasserts.

Test Plan:
- Single master 0 writes 0xDEADBEEF to addr 0x0010 with be=0xF, then reads addr 0x0010 -> write accepted with waitrequest=0 same cycle; read accepted; m_readdatavalid=2'b01 and m_readdata=0xDEADBEEF exactly one cycle later.
- Both masters request reads continuously after reset -> grants alternate 0,1,0,1; each master gets readdatavalid every other cycle; mem_chipselect=1 every cycle.
- Master 0 byte write be=0x2 data 0x0000AB00 over 0x11223344, then read -> 0x1122AB44.
- Master 1 locked reads, MAX_LOCK=4, master 0 requesting -> master 1 granted 4 consecutive cycles, then master 0 granted; master 1 regranted afterwards.
- Assert reset_n=0 in the cycle after a granted read -> no readdatavalid; after release, master 0 wins a simultaneous request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Lets NUM_MASTERS processor data masters share one single-port on-chip RAM.
//   The arbiter is round-robin and supports an optional lock, which is bounded
//   to MAX_LOCK consecutive grants. At most one RAM access is issued per cycle.
//   The RAM registers its address and has an unregistered output, so read
//   data comes back one cycle after the access. That data is passed straight
//   through to the masters, together with a one-hot readdatavalid strobe.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   m_address        per-master word address, master i in slice i
//   m_byteenable     per-master byte enables
//   m_read/m_write   per-master request (write wins if both are set)
//   m_writedata      per-master write data
//   m_lock           per-master request to keep the grant next cycle
//   m_waitrequest    per-master, high = not accepted this cycle
//   m_readdata       read data shared by all masters
//   m_readdatavalid  one-hot owner of m_readdata this cycle
//   mem_*            single-port RAM interface (mem_clken tied high)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 15,
    parameter int MAX_LOCK    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*4-1:0]      m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*32-1:0]     m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [31:0]                   m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [3:0]                    mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [31:0]                   mem_writedata,
    output logic                          mem_clken,
    input  logic [31:0]                   mem_readdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    // LOCK_HELD   : lock_owner wins as long as it keeps requesting.
    // LOCK_EXPIRED: the lock ran out last cycle. This cycle is arbitrated
    //               round-robin, and m_lock is ignored, so the other masters
    //               are guaranteed one chance at the RAM.
    typedef enum logic [1:0] {
        LOCK_FREE,
        LOCK_HELD,
        LOCK_EXPIRED
    } lock_state_t;

    lock_state_t      lock_state, lock_state_nxt;
    logic [IDX_W-1:0] lock_owner, lock_owner_nxt;
    logic [7:0]       lock_cnt, lock_cnt_nxt, cnt_inc;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] rd_owner;
    logic             rd_pend;

    logic [NUM_MASTERS-1:0] req;
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic                   out_vld;

    // Returns the first requester, searching upward from (last+1) and
    // wrapping modulo NUM_MASTERS. The loop runs from the farthest offset to
    // the nearest one, so the nearest requester is written last and wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                                 input logic [IDX_W-1:0]       last);
        logic [IDX_W-1:0] pick;
        logic [SUM_W-1:0] cand;
        pick = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = SUM_W'(last) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_MASTERS)) cand = cand - SUM_W'(NUM_MASTERS);
            if (r[cand[IDX_W-1:0]]) pick = cand[IDX_W-1:0];
        end
        return pick;
    endfunction

    assign req = m_read | m_write;

    // Arbitration. A lock whose owner has stopped requesting is simply
    // ignored here, so it never stalls the other masters.
    // NOTE: every signal written in always_comb gets a default before any
    // branch; without one, a missed path would infer a latch.
    always_comb begin
        grant_vld = |req;
        grant_idx = '0;
        if (lock_state == LOCK_HELD && req[lock_owner]) begin
            grant_idx = lock_owner;
        end else if (grant_vld) begin
            grant_idx = rr_pick(req, last_grant);
        end
    end

    // Lock bookkeeping. The lock is granted again only when the grantee asks
    // for it. When the count reaches MAX_LOCK, the current grant is still
    // honoured and the lock is dropped into LOCK_EXPIRED for one cycle.
    always_comb begin
        lock_state_nxt = LOCK_FREE;
        lock_owner_nxt = lock_owner;
        lock_cnt_nxt   = '0;
        cnt_inc        = 8'd1;
        if (grant_vld && m_lock[grant_idx] && lock_state != LOCK_EXPIRED) begin
            if (lock_state == LOCK_HELD && lock_owner == grant_idx) begin
                cnt_inc = lock_cnt + 8'd1;
            end
            if (cnt_inc >= LOCK_LIMIT) begin
                lock_state_nxt = LOCK_EXPIRED;
            end else begin
                lock_state_nxt = LOCK_HELD;
                lock_owner_nxt = grant_idx;
                lock_cnt_nxt   = cnt_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            rd_pend    <= 1'b0;
            rd_owner   <= '0;
            lock_state <= LOCK_FREE;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            // A granted request that is not a write is a read.
            rd_pend    <= grant_vld & ~m_write[grant_idx];
            if (grant_vld) begin
                rd_owner   <= grant_idx;
                last_grant <= grant_idx;
            end
            lock_state <= lock_state_nxt;
            lock_owner <= lock_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // While reset is held, grants are masked from the outputs only. The
    // registers are already forced by the reset branch and ignore their
    // inputs.
    assign out_vld = grant_vld & reset_n;

    always_comb begin
        m_waitrequest = '1;
        if (out_vld) m_waitrequest[grant_idx] = 1'b0;
    end

    // When nobody is granted, grant_idx is 0, so the don't-care address and
    // data outputs come from master 0's slice.
    assign mem_address    = m_address[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign mem_byteenable = m_byteenable[int'(grant_idx)*4 +: 4];
    assign mem_writedata  = m_writedata[int'(grant_idx)*32 +: 32];
    assign mem_chipselect = out_vld;
    assign mem_write      = out_vld & m_write[grant_idx];
    assign mem_clken      = 1'b1;

    // The RAM output is already aligned with rd_pend, so it is passed
    // straight through.
    always_comb begin
        m_readdatavalid = '0;
        if (rd_pend) m_readdatavalid[rd_owner] = 1'b1;
    end

    assign m_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter, configured with 2 masters, 15-bit
// addresses and MAX_LOCK=4. A small behavioural RAM is attached. It has a
// registered address and an unregistered output. Inputs change 1 ns after
// the rising edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*AW-1:0] m_address;
    logic [N*4-1:0]  m_byteenable;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*32-1:0] m_writedata;
    logic [N-1:0]    m_lock;
    logic [N-1:0]    m_waitrequest;
    logic [31:0]     m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic [3:0]      mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [31:0]     mem_writedata;
    logic            mem_clken;
    logic [31:0]     mem_readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_MASTERS(N),
        .ADDR_W     (AW),
        .MAX_LOCK   (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_lock         (m_lock),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // Behavioural single-port RAM: 64 words, registered address,
    // combinational read, byte-enabled write.
    logic [31:0] ram [0:63];
    logic [5:0]  ram_aq;

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address[5:0]][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            ram_aq <= mem_address[5:0];
        end
    end

    assign mem_readdata = ram[ram_aq];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic rd, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        m_read[i]                = rd;
        m_write[i]               = wr;
        m_lock[i]                = lk;
        m_address[i*AW +: AW]    = a;
        m_byteenable[i*4 +: 4]   = be;
        m_writedata[i*32 +: 32]  = d;
    endtask

    task automatic idle_all();
        m_read  = '0;
        m_write = '0;
        m_lock  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset with requests pending: outputs must stay quiet ----
        reset_n      = 1'b0;
        m_address    = '0;
        m_byteenable = '1;
        m_writedata  = '0;
        idle_all();
        m_read  = 2'b11;
        m_write = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait",  32'(m_waitrequest),   32'h3);
        check("rst_rdv",   32'(m_readdatavalid), 32'h0);
        check("rst_cs",    32'(mem_chipselect),  32'h0);
        check("rst_wr",    32'(mem_write),       32'h0);
        check("rst_clken", 32'(mem_clken),       32'h1);
        idle_all();
        reset_n = 1'b1;
        next_cycle();

        // ---- single master write then read back ----
        drive(0, 1'b0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_wait", 32'(m_waitrequest),  32'h2);
        check("wr_cs",   32'(mem_chipselect), 32'h1);
        check("wr_we",   32'(mem_write),      32'h1);
        check("wr_addr", 32'(mem_address),    32'h10);
        check("wr_data", mem_writedata,       32'hDEADBEEF);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check("rd_wait",     32'(m_waitrequest),   32'h2);
        check("rd_we",       32'(mem_write),       32'h0);
        check("wr_no_resp",  32'(m_readdatavalid), 32'h0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("rd_rdv",  32'(m_readdatavalid), 32'h1);
        check("rd_data", m_readdata,           32'hDEADBEEF);
        check("idle_cs", 32'(mem_chipselect),  32'h0);
        next_cycle();

        // ---- byte-enable write merge ----
        drive(0, 1'b0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h11223344);
        next_cycle();
        drive(0, 1'b0, 1'b1, 1'b0, 15'h0020, 4'h2, 32'h0000AB00);
        @(negedge clk);
        check("be_be", 32'(mem_byteenable), 32'h2);
        next_cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("be_rdv",  32'(m_readdatavalid), 32'h1);
        check("be_data", m_readdata,           32'h1122AB44);
        next_cycle();

        // ---- lock: master 1 held for MAX_LOCK=4 grants, master 0 waiting ----
        drive(1, 1'b1, 1'b0, 1'b1, 15'h0010, 4'hF, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("lock_wait%0d", c), 32'(m_waitrequest), 32'h1);
            if (c > 1) begin
                check($sformatf("lock_rdv%0d", c),  32'(m_readdatavalid), 32'h2);
                check($sformatf("lock_data%0d", c), m_readdata,           32'hDEADBEEF);
            end
            next_cycle();
        end
        @(negedge clk);
        check("expire_wait", 32'(m_waitrequest),   32'h2);
        check("expire_rdv",  32'(m_readdatavalid), 32'h2);
        next_cycle();
        @(negedge clk);
        check("regrant_wait", 32'(m_waitrequest),   32'h1);
        check("regrant_rdv",  32'(m_readdatavalid), 32'h1);
        check("regrant_data", m_readdata,           32'h1122AB44);
        next_cycle();
        m_lock[1] = 1'b0;
        @(negedge clk);
        check("unlock_hold", 32'(m_waitrequest), 32'h1);
        next_cycle();
        @(negedge clk);
        check("unlock_rr", 32'(m_waitrequest), 32'h2);
        next_cycle();
        m_lock[1] = 1'b1;
        @(negedge clk);
        check("relock_wait", 32'(m_waitrequest), 32'h1);
        next_cycle();
        m_read[1] = 1'b0;
        @(negedge clk);
        check("owner_gone", 32'(m_waitrequest), 32'h2);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("owner_gone_rdv",  32'(m_readdatavalid), 32'h1);
        check("owner_gone_data", m_readdata,           32'h1122AB44);
        check("owner_gone_cs",   32'(mem_chipselect),  32'h0);
        next_cycle();

        // ---- reset in the cycle after a granted read ----
        drive(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check("pre_rst_wait", 32'(m_waitrequest), 32'h2);
        next_cycle();
        reset_n = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        @(negedge clk);
        check("mid_rst_rdv",  32'(m_readdatavalid), 32'h0);
        check("mid_rst_wait", 32'(m_waitrequest),   32'h3);
        check("mid_rst_cs",   32'(mem_chipselect),  32'h0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_wait", 32'(m_waitrequest),   32'h2);
        check("post_rst_rdv",  32'(m_readdatavalid), 32'h0);
        next_cycle();

        // ---- continuous reads from both masters: strict alternation ----
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("alt_wait%0d", k), 32'(m_waitrequest),
                  (k % 2 == 1) ? 32'h1 : 32'h2);
            check($sformatf("alt_rdv%0d", k), 32'(m_readdatavalid),
                  (k % 2 == 1) ? 32'h1 : 32'h2);
            check($sformatf("alt_data%0d", k), m_readdata,
                  (k % 2 == 1) ? 32'hDEADBEEF : 32'h1122AB44);
            check($sformatf("alt_cs%0d", k), 32'(mem_chipselect), 32'h1);
            next_cycle();
        end
        idle_all();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
